// File: rtl/vga_timing_gen_if.sv
// Scan-coordinate and sync bundle driven by vga_timing_gen toward the sprite
// renderers and the VGA connector.
interface vga_timing_gen_if;
  logic [11:0] pixel_row;
  logic [11:0] pixel_column;
  logic        video_on;
  logic        hsync;
  logic        vsync;
  logic        line_start;
  logic        frame_start;

  modport master (
    output pixel_row, pixel_column, video_on, hsync, vsync, line_start, frame_start
  );
  modport slave (
    input  pixel_row, pixel_column, video_on, hsync, vsync, line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing: 12-bit h/v counters with matching phase FSMs; every output
// is registered and reflects the counter state loaded on the same pix_en edge.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_en,
  vga_timing_gen_if.master vga
);

  localparam logic [11:0] H_TOTAL    = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam logic [11:0] H_FP_START = 12'(H_ACTIVE);
  localparam logic [11:0] H_SY_START = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] H_BP_START = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] V_TOTAL    = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam logic [11:0] V_FP_START = 12'(V_ACTIVE);
  localparam logic [11:0] V_SY_START = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] V_BP_START = 12'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FRONT  = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BACK   = 2'd3
  } phase_e;

  // Phase step keyed on the count about to be loaded, so state and counter
  // always change together on the same edge.
  function automatic phase_e next_phase(
    input phase_e      cur,
    input logic [11:0] cnt_nxt,
    input logic [11:0] fp_s,
    input logic [11:0] sy_s,
    input logic [11:0] bp_s
  );
    phase_e nxt;
    nxt = cur;
    case (cur)
      PH_ACTIVE: if (cnt_nxt == fp_s) nxt = PH_FRONT;
      PH_FRONT:  if (cnt_nxt == sy_s) nxt = PH_SYNC;
      PH_SYNC:   if (cnt_nxt == bp_s) nxt = PH_BACK;
      PH_BACK:   if (cnt_nxt == '0)   nxt = PH_ACTIVE;
      default:   nxt = PH_ACTIVE;
    endcase
    return nxt;
  endfunction

  logic [11:0] h_cnt_q, h_cnt_d;
  logic [11:0] v_cnt_q, v_cnt_d;
  phase_e      h_st_q, h_st_d;
  phase_e      v_st_q, v_st_d;
  logic        video_on_q, video_on_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        line_start_q, line_start_d;
  logic        frame_start_q, frame_start_d;
  logic        h_wrap, v_wrap;

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    h_wrap  = 1'b0;
    v_wrap  = 1'b0;
    if (pix_en) begin
      if (h_cnt_q == H_TOTAL - 12'd1) begin
        h_cnt_d = '0;
        h_wrap  = 1'b1;
        if (v_cnt_q == V_TOTAL - 12'd1) begin
          v_cnt_d = '0;
          v_wrap  = 1'b1;
        end else begin
          v_cnt_d = v_cnt_q + 12'd1;
        end
      end else begin
        h_cnt_d = h_cnt_q + 12'd1;
      end
    end
  end

  always_comb begin
    h_st_d = h_st_q;
    v_st_d = v_st_q;
    if (pix_en) h_st_d = next_phase(h_st_q, h_cnt_d, H_FP_START, H_SY_START, H_BP_START);
    if (h_wrap) v_st_d = next_phase(v_st_q, v_cnt_d, V_FP_START, V_SY_START, V_BP_START);
  end

  // video_on stays low after reset until the first enabled edge.
  always_comb begin
    video_on_d    = video_on_q;
    hsync_d       = (h_st_d == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
    vsync_d       = (v_st_d == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
    line_start_d  = h_wrap;
    frame_start_d = h_wrap & v_wrap;
    if (pix_en) video_on_d = (h_st_d == PH_ACTIVE) && (v_st_d == PH_ACTIVE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      h_st_q        <= PH_ACTIVE;
      v_st_q        <= PH_ACTIVE;
      video_on_q    <= 1'b0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      h_st_q        <= h_st_d;
      v_st_q        <= v_st_d;
      video_on_q    <= video_on_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga.pixel_row    = v_cnt_q;
  assign vga.pixel_column = h_cnt_q;
  assign vga.video_on     = video_on_q;
  assign vga.hsync        = hsync_q;
  assign vga.vsync        = vsync_q;
  assign vga.line_start   = line_start_q;
  assign vga.frame_start  = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a full-size 640x480 instance for line timing and a tiny
// active-high-sync instance (15x11 raster) for frame timing and pix_en toggling.
module tb_vga_timing_gen;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic pe_a = 1'b0;
  logic pe_b = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  vga_timing_gen_if a_if ();
  vga_timing_gen_if b_if ();

  vga_timing_gen u_a (.clk(clk), .rst(rst), .pix_en(pe_a), .vga(a_if));

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .SYNC_POL(1'b1)
  ) u_b (.clk(clk), .rst(rst), .pix_en(pe_b), .vga(b_if));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input int row, input int col, input int von,
                       input int hs, input int vs, input int ls, input int fs);
    chk({tag, ".row"}, int'(a_if.pixel_row), row);
    chk({tag, ".col"}, int'(a_if.pixel_column), col);
    chk({tag, ".von"}, int'(a_if.video_on), von);
    chk({tag, ".hs"},  int'(a_if.hsync), hs);
    chk({tag, ".vs"},  int'(a_if.vsync), vs);
    chk({tag, ".ls"},  int'(a_if.line_start), ls);
    chk({tag, ".fs"},  int'(a_if.frame_start), fs);
  endtask

  task automatic chk_b(input string tag, input int row, input int col, input int von,
                       input int hs, input int vs, input int ls, input int fs);
    chk({tag, ".row"}, int'(b_if.pixel_row), row);
    chk({tag, ".col"}, int'(b_if.pixel_column), col);
    chk({tag, ".von"}, int'(b_if.video_on), von);
    chk({tag, ".hs"},  int'(b_if.hsync), hs);
    chk({tag, ".vs"},  int'(b_if.vsync), vs);
    chk({tag, ".ls"},  int'(b_if.line_start), ls);
    chk({tag, ".fs"},  int'(b_if.frame_start), fs);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int cyc_start;
    int fs_n;
    int ls_n;
    int wide;
    int fs_t [2];

    // Reset values (A: active-low sync idles high; B: active-high idles low)
    tick(2);
    chk_a("a_rst", 0, 0, 0, 1, 1, 0, 0);
    chk_b("b_rst", 0, 0, 0, 0, 0, 0, 0);

    // Full-size line timing
    rst = 1'b1; pe_a = 1'b1;
    tick(1);   chk_a("a_first", 0, 1, 1, 1, 1, 0, 0);
    tick(654); chk_a("a_c655", 0, 655, 0, 1, 1, 0, 0);
    tick(1);   chk_a("a_c656", 0, 656, 0, 0, 1, 0, 0);
    tick(95);  chk_a("a_c751", 0, 751, 0, 0, 1, 0, 0);
    tick(1);   chk_a("a_c752", 0, 752, 0, 1, 1, 0, 0);
    tick(47);  chk_a("a_c799", 0, 799, 0, 1, 1, 0, 0);
    tick(1);   chk_a("a_wrap", 1, 0, 1, 1, 1, 1, 0);
    tick(1);   chk_a("a_r1c1", 1, 1, 1, 1, 1, 0, 0);

    pe_a = 1'b0;
    tick(3);   chk_a("a_hold", 1, 1, 1, 1, 1, 0, 0);
    pe_a = 1'b1;
    tick(1199); chk_a("a_r2c400", 2, 400, 1, 1, 1, 0, 0);

    // Asynchronous reset mid-frame, then restart from (0,0)
    rst = 1'b0;
    #1;        chk_a("a_async_rst", 0, 0, 0, 1, 1, 0, 0);
    @(negedge clk); rst = 1'b1;
    tick(1);   chk_a("a_restart", 0, 1, 1, 1, 1, 0, 0);
    pe_a = 1'b0;

    // Small raster: H 0-7 act, 8-9 fp, 10-12 sync, 13-14 bp; V 0-5, 6, 7-8, 9-10
    cyc_start = cyc;
    pe_b = 1'b1;
    tick(1);   chk_b("b_first", 0, 1, 1, 0, 0, 0, 0);
    tick(8);   chk_b("b_c9", 0, 9, 0, 0, 0, 0, 0);
    tick(1);   chk_b("b_c10", 0, 10, 0, 1, 0, 0, 0);
    tick(2);   chk_b("b_c12", 0, 12, 0, 1, 0, 0, 0);
    tick(1);   chk_b("b_c13", 0, 13, 0, 0, 0, 0, 0);
    tick(2);   chk_b("b_wrap", 1, 0, 1, 0, 0, 1, 0);
    tick(89);  chk_b("b_r6c14", 6, 14, 0, 0, 0, 0, 0);
    tick(1);   chk_b("b_vs_on", 7, 0, 0, 0, 1, 1, 0);
    tick(29);  chk_b("b_r8c14", 8, 14, 0, 0, 1, 0, 0);
    tick(1);   chk_b("b_vs_off", 9, 0, 0, 0, 0, 1, 0);
    tick(29);  chk_b("b_r10c14", 10, 14, 0, 0, 0, 0, 0);
    tick(1);   chk_b("b_frame", 0, 0, 1, 0, 0, 1, 1);
    chk("b_frame_len", cyc - cyc_start, 165);
    tick(1);   chk_b("b_after_fs", 0, 1, 1, 0, 0, 0, 0);

    // pix_en toggling: advance every 2nd clk, strobes only on enabled edges
    fs_n = 0; ls_n = 0; wide = 0; fs_t[0] = 0; fs_t[1] = 0;
    for (int i = 0; i < 330; i++) begin
      pe_b = 1'b1;
      @(negedge clk);
      if (b_if.frame_start) begin
        if (fs_n < 2) fs_t[fs_n] = cyc;
        fs_n++;
      end
      if (b_if.line_start) ls_n++;
      pe_b = 1'b0;
      @(negedge clk);
      if (b_if.line_start || b_if.frame_start) wide++;
    end
    chk("b_tog_fs_count", fs_n, 2);
    chk("b_tog_frame_len", fs_t[1] - fs_t[0], 330);
    chk("b_tog_ls_count", ls_n, 22);
    chk("b_tog_wide", wide, 0);
    chk_b("b_tog_end", 0, 1, 1, 0, 0, 0, 0);

    // Mid-frame reset on the small raster
    pe_b = 1'b1;
    tick(64);  chk_b("b_r4c5", 4, 5, 1, 0, 0, 0, 0);
    rst = 1'b0;
    #1;        chk_b("b_async_rst", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); rst = 1'b1;
    tick(1);   chk_b("b_restart", 0, 1, 1, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
